// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// S1 registers per-4-bit-block generate/propagate and both speculative block
// sums; S2 resolves block carries by second-level lookahead, selects the
// block sums and registers the result. A valid/ready handshake stalls both
// stages together.

// One 4-bit lookahead block: group generate/propagate plus the block sum for
// carry-in 0 and for carry-in 1.
module cla_blk (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_g,
    output logic       o_p,
    output logic [3:0] o_s0,
    output logic [3:0] o_s1
);
    logic [3:0] w_g;
    logic [3:0] w_p;

    assign w_g  = i_a & i_b;
    assign w_p  = i_a ^ i_b;
    assign o_g  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p  = &w_p;
    assign o_s0 = i_a + i_b;
    assign o_s1 = i_a + i_b + 4'd1;
endmodule

module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NB = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 8 || BLOCK != 4) begin : g_bad_param
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 and >= 8, BLOCK must be 4");
    end

    // Operand conditioning: subtraction is a + ~b + 1
    logic [WIDTH-1:0]     w_bx;
    logic                 w_cin0;
    logic [NB-1:0]        w_g;
    logic [NB-1:0]        w_p;
    logic [NB-1:0][3:0]   w_s0;
    logic [NB-1:0][3:0]   w_s1;

    assign w_bx   = sub ? ~b : b;
    assign w_cin0 = sub ? 1'b1 : c_in;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        cla_blk u_blk (
            .i_a  (a[4*k +: 4]),
            .i_b  (w_bx[4*k +: 4]),
            .o_g  (w_g[k]),
            .o_p  (w_p[k]),
            .o_s0 (w_s0[k]),
            .o_s1 (w_s1[k])
        );
    end

    // Stage registers
    logic                 r_s1_vld;
    logic [NB-1:0]        r_s1_g;
    logic [NB-1:0]        r_s1_p;
    logic [NB-1:0][3:0]   r_s1_s0;
    logic [NB-1:0][3:0]   r_s1_s1;
    logic                 r_s1_cin;
    logic                 r_s1_sa;
    logic                 r_s1_sb;

    logic                 r_s2_vld;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_ovf;
    logic                 r_zero;

    logic                 w_adv;
    logic                 w_ov;
    logic [NB:0]          w_c;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_ovf;
    logic                 w_zero;

    // Output is masked during reset so no transfer can happen in that cycle
    assign w_ov      = r_s2_vld & ~reset;
    assign w_adv     = ~w_ov | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = w_ov;
    assign sum       = w_ov ? r_sum : '0;
    assign c_out     = w_ov & r_cout;
    assign overflow  = w_ov & r_ovf;
    assign zero      = w_ov & r_zero;

    // Second-level lookahead across blocks, then per-block carry-select
    always_comb begin
        w_c    = '0;
        w_c[0] = r_s1_cin;
        w_sum  = '0;
        for (int k = 0; k < NB; k++) begin
            w_c[k+1]       = r_s1_g[k] | (r_s1_p[k] & w_c[k]);
            w_sum[4*k +: 4] = w_c[k] ? r_s1_s1[k] : r_s1_s0[k];
        end
    end

    assign w_zero = (w_sum == '0);
    assign w_ovf  = (r_s1_sa == r_s1_sb) && (w_sum[WIDTH-1] != r_s1_sa);

    // S1: capture block lookahead terms when the pipe advances
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld <= in_valid;
            r_s1_g   <= w_g;
            r_s1_p   <= w_p;
            r_s1_s0  <= w_s0;
            r_s1_s1  <= w_s1;
            r_s1_cin <= w_cin0;
            r_s1_sa  <= a[WIDTH-1];
            r_s1_sb  <= w_bx[WIDTH-1];
        end
    end

    // S2: register the resolved result when the pipe advances
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_vld <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_adv) begin
            r_s2_vld <= r_s1_vld;
            r_sum    <= w_sum;
            r_cout   <= w_c[NB];
            r_ovf    <= w_ovf;
            r_zero   <= w_zero;
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: the driver pushes model results on
// every accepted input, the monitor pops and compares on every output transfer.
module tb_cla_pipe_adder;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        c_in, sub;
    logic        out_valid, out_ready;
    logic [31:0] sum;
    logic        c_out, overflow, zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    exp_t q[$];

    cla_pipe_adder #(.WIDTH(32), .BLOCK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed overflow by range check
    function automatic exp_t model(input logic [31:0] xa, input logic [31:0] xb,
                                   input logic ci, input logic sb);
        exp_t        e;
        longint      sa, sbv, sr;
        longint unsigned r;
        sa  = longint'($signed(xa));
        sbv = longint'($signed(xb));
        if (sb) begin
            e.s  = xa - xb;
            e.co = (xa >= xb);
            sr   = sa - sbv;
        end else begin
            r    = longint'(xa) + longint'(xb) + longint'(ci);
            e.s  = r[31:0];
            e.co = r[32];
            sr   = sa + sbv + longint'(ci);
        end
        e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.z  = (e.s == 32'd0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; reports whether an input transfer happened
    task automatic drive(input logic [31:0] xa, input logic [31:0] xb, input logic ci,
                         input logic sb, input logic v, input logic r, input logic rst,
                         output bit acc);
        @(posedge clk);
        #1;
        a = xa; b = xb; c_in = ci; sub = sb;
        in_valid = v; out_ready = r; reset = rst;
        @(negedge clk);
        acc = in_valid && in_ready && !reset;
        if (acc) q.push_back(model(xa, xb, ci, sb));
    endtask

    task automatic idle(input logic r, output bit acc);
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, r, 1'b0, acc);
    endtask

    // Single operation with exact-latency and constant-result checks
    task automatic op_single(input string nm, input logic [31:0] xa, input logic [31:0] xb,
                             input logic ci, input logic sb, input logic [31:0] es,
                             input logic eco, input logic eov, input logic ez);
        bit acc;
        drive(xa, xb, ci, sb, 1'b1, 1'b1, 1'b0, acc);
        chk({nm, "_accept"}, 64'(acc), 64'd1);
        idle(1'b1, acc);
        chk({nm, "_lat1_valid"}, 64'(out_valid), 64'd0);
        idle(1'b1, acc);
        chk({nm, "_lat2_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_result"}, {29'd0, sum, c_out, overflow, zero}, {29'd0, es, eco, eov, ez});
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: scoreboard compare, idle-zero and stall-stability checks
    initial begin
        exp_t        e;
        bit          prev_stall = 1'b0;
        logic [34:0] prev_data  = '0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", {29'd0, sum, c_out, overflow, zero}, {29'd0, e.s, e.co, e.ov, e.z});
                end
            end
            if (!out_valid)
                chk("idle_zero", {29'd0, sum, c_out, overflow, zero}, 64'd0);
            if (prev_stall && !reset)
                chk("stall_stable", {29'd0, sum, c_out, overflow, zero}, {29'd0, prev_data});
            prev_stall = out_valid && !out_ready && !reset;
            prev_data  = {sum, c_out, overflow, zero};
        end
    end

    initial begin
        bit acc;
        int n, cyc;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

        // Reset with an input presented: must not be captured
        drive(32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        drive(32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_outputs", {29'd0, sum, c_out, overflow, zero}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, acc);
            chk("post_rst_no_out", 64'(out_valid), 64'd0);
        end

        // Directed corner cases
        op_single("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        op_single("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        op_single("sub_neg",  32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        op_single("add_cin",  32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        op_single("sub_min",  32'h0, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Stall: two ops enter, third is refused while the output is held
        drive(32'd10, 32'd20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        chk("stall_acc1", 64'(acc), 64'd1);
        drive(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        chk("stall_acc2", 64'(acc), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive(32'd3, 32'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_first_sum", 64'(sum), 64'd30);
        end
        drive(32'd3, 32'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        chk("release_acc3", 64'(acc), 64'd1);
        chk("release_r1", 64'({out_valid, sum}), {31'd0, 1'b1, 32'd30});
        idle(1'b1, acc);
        chk("release_r2", 64'({out_valid, sum}), {31'd0, 1'b1, 32'd0});
        idle(1'b1, acc);
        chk("release_r3", 64'({out_valid, sum}), {31'd0, 1'b1, 32'hFFFF_FFFF});
        idle(1'b1, acc);
        chk("release_done", 64'(out_valid), 64'd0);

        // Reset with two ops in flight: everything discarded
        drive(32'd100, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        drive(32'd200, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        drive(32'd300, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        q.delete();
        chk("midrst_masked", 64'(out_valid), 64'd0);
        idle(1'b1, acc);
        chk("midrst_after", 64'({out_valid, sum}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, acc);
            chk("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        // Random traffic with random backpressure
        n = 0; cyc = 0;
        while (n < 10000 && cyc < 60000) begin
            drive(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'b0, acc);
            if (acc) n++;
            cyc++;
        end
        chk("rand_issued", 64'(n), 64'd10000);

        // Drain and confirm every expected result came out
        for (int i = 0; i < 6; i++) idle(1'b1, acc);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
